seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder_pkg.sv | 23 ++
 rtl/seg_add_stage.sv | 42 ++++
 rtl/seg_pipe_adder.sv | 147 ++++++++++++++
 tb/tb_seg_pipe_adder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pipe_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seg_pipe_adder_pkg                                           |
// | Description : Shared sizing helpers for the segmented pipelined adder.     |
// |               nseg_f    : number of segments (and pipeline stages).        |
// |               top_seg_w : width of the top segment, which takes whatever   |
// |                           bits remain after the full-width lower segments. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg_pipe_adder_pkg;

  // Number of segments: ceil(width / seg).
  function automatic int nseg_f(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // Width of the most-significant segment.
  function automatic int top_seg_w(input int width, input int seg);
    return width - (nseg_f(width, seg) - 1) * seg;
  endfunction

endpackage : seg_pipe_adder_pkg
`default_nettype wire

// File: rtl/seg_add_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_add_stage                                                |
// | Description : Combinational ripple-carry adder for one pipeline segment.   |
// | Ports       : a, b   [W-1:0]  segment operands (b already inverted for sub)|
// |               ci              carry into bit 0 of the segment              |
// |               s      [W-1:0]  segment sum                                  |
// |               co              carry out of the segment MSB                 |
// |               c_msb           carry into the segment MSB (overflow detect) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_add_stage
  import seg_pipe_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // w_c[i] is the carry into bit i; w_c[W] is the segment carry-out.
  logic [W:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = w_c[W];
  assign c_msb = w_c[W-1];

endmodule : seg_add_stage
`default_nettype wire

// File: rtl/seg_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_pipe_adder                                               |
// | Description : Segmented pipelined adder/subtractor. One segment of SEG bits|
// |               is added per stage, the carry ripples stage to stage, and    |
// |               operand/sum skew registers keep each beat aligned so the     |
// |               whole result exits NSEG enabled cycles after acceptance.     |
// | Ports       : clk, rst (async, active-high), en (advance, low = stall)     |
// |               in_valid, a, b, cin, sub  : input beat                       |
// |               out_valid, sum, carry, ovf: registered result beat           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NSEG  = nseg_f(WIDTH, SEG);
  localparam int TOP_W = top_seg_w(WIDTH, SEG);

  // Per-stage inputs. Operands are right-shifted as they move down the pipe,
  // so stage k always finds its segment in the low bits. The partial sum
  // accumulates completed segments in their final bit positions.
  logic [WIDTH-1:0] w_a [NSEG];
  logic [WIDTH-1:0] w_b [NSEG];
  logic [WIDTH-1:0] w_s [NSEG];
  logic             w_c [NSEG];
  logic             w_v [NSEG];

  // Subtraction is folded in at acceptance, so the mode travels with its beat
  // implicitly through the inverted operand and carry.
  assign w_a[0] = a;
  assign w_b[0] = b ^ {WIDTH{sub}};
  assign w_c[0] = cin ^ sub;
  assign w_v[0] = in_valid;
  assign w_s[0] = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int SW = (k == NSEG - 1) ? TOP_W : SEG;

    logic [SW-1:0]    w_seg;
    logic             w_co;
    logic             w_cm;
    logic [WIDTH-1:0] w_seg_ext;
    logic [WIDTH-1:0] w_snext;

    seg_add_stage #(.W(SW)) u_add (
      .a     (w_a[k][SW-1:0]),
      .b     (w_b[k][SW-1:0]),
      .ci    (w_c[k]),
      .s     (w_seg),
      .co    (w_co),
      .c_msb (w_cm)
    );

    always_comb begin
      w_seg_ext         = '0;
      w_seg_ext[SW-1:0] = w_seg;
    end

    assign w_snext = w_s[k] | (w_seg_ext << LO);

    if (k < NSEG - 1) begin : g_mid
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;
      logic             r_v;
      logic             w_cm_unused;

      // Data only loads for a real beat, so bubbles leave the payload intact.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
        end else if (en) begin
          r_v <= w_v[k];
          if (w_v[k]) begin
            r_a <= w_a[k] >> SW;
            r_b <= w_b[k] >> SW;
            r_s <= w_snext;
            r_c <= w_co;
          end
        end
      end

      assign w_a[k+1]    = r_a;
      assign w_b[k+1]    = r_b;
      assign w_s[k+1]    = r_s;
      assign w_c[k+1]    = r_c;
      assign w_v[k+1]    = r_v;
      // Only the top segment's MSB carry feeds overflow detection.
      assign w_cm_unused = w_cm;
    end else begin : g_last
      logic [WIDTH-1:0]   r_s;
      logic               r_c;
      logic               r_ovf;
      logic               r_v;
      logic [2*WIDTH-1:0] w_ops_unused;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_s   <= '0;
          r_c   <= 1'b0;
          r_ovf <= 1'b0;
        end else if (en) begin
          r_v <= w_v[k];
          if (w_v[k]) begin
            r_s   <= w_snext;
            r_c   <= w_co;
            r_ovf <= w_cm ^ w_co;
          end
        end
      end

      // Bits above the top segment are already exhausted at this stage.
      assign w_ops_unused = {w_a[k], w_b[k]};

      assign out_valid = r_v;
      assign sum       = r_s;
      assign carry     = r_c;
      assign ovf       = r_ovf;
    end
  end : g_stage

endmodule : seg_pipe_adder
`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_pipe_adder                                            |
// | Description : Self-checking bench for seg_pipe_adder (WIDTH=13, SEG=4).    |
// |               Directed beats with hand-computed results, a stall window,   |
// |               a streaming burst and a mid-flight reset. Expected results   |
// |               are queued with the enabled-cycle count at which they are    |
// |               due and compared against every output on every cycle.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_pipe_adder;

  localparam int WIDTH = 13;
  localparam int SEG   = 4;
  localparam int LAT   = 4;

  typedef struct packed {
    int              due;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  seg_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    ecnt   = 0;
  string phase  = "init";
  exp_t  q [$];

  // Expected output state; changes only on enabled edges.
  logic             xv;
  logic [WIDTH-1:0] xs;
  logic             xc;
  logic             xo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t r;
    r.due   = 0;
    r.sum   = s;
    r.carry = c;
    r.ovf   = o;
    return r;
  endfunction

  // Arithmetic reference: subtraction as a + ~b + ~cin, overflow by sign rule.
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tci, input logic ts);
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH:0]   t;
    be = ts ? ~tb : tb;
    ce = ts ? ~tci : tci;
    t  = {1'b0, ta} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    return mk(t[WIDTH-1:0], t[WIDTH],
              (ta[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != ta[WIDTH-1]));
  endfunction

  task automatic check_out();
    check("out_valid", 64'(out_valid), 64'(xv));
    check("sum",       64'(sum),       64'(xs));
    check("carry",     64'(carry),     64'(xc));
    check("ovf",       64'(ovf),       64'(xo));
  endtask

  // One clock: drive inputs, take the edge, update expectations, check #1 later.
  task automatic cyc(input logic e, input logic v, input logic [WIDTH-1:0] ta,
                     input logic [WIDTH-1:0] tb, input logic tci, input logic ts,
                     input exp_t ex);
    exp_t cur;
    en       = e;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tci;
    sub      = ts;
    @(posedge clk);
    if (e) begin
      ecnt++;
      if (v) begin
        cur     = ex;
        cur.due = ecnt + LAT - 1;
        q.push_back(cur);
      end
      if (q.size() > 0 && q[0].due == ecnt) begin
        cur = q.pop_front();
        xv  = 1'b1;
        xs  = cur.sum;
        xc  = cur.carry;
        xo  = cur.ovf;
      end else begin
        xv = 1'b0;
      end
    end
    #1;
    check_out();
  endtask

  task automatic beat_h(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tci, input logic ts,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    cyc(1'b1, 1'b1, ta, tb, tci, ts, mk(es, ec, eo));
  endtask

  task automatic beat_m(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tci, input logic ts);
    cyc(1'b1, 1'b1, ta, tb, tci, ts, model(ta, tb, tci, ts));
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 13'h1ABC, 13'h0DEF, 1'b1, 1'b1, mk('0, 1'b0, 1'b0));
  endtask

  task automatic clear_model();
    q.delete();
    xv = 1'b0;
    xs = '0;
    xc = 1'b0;
    xo = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    clear_model();

    // Reset state, asserted between edges.
    phase = "reset";
    #1 rst = 1'b1;
    #1 check_out();
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed beats, back to back, hand-computed results.
    phase = "directed";
    beat_h(13'h1FFF, 13'h0001, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0); // add wrap
    beat_h(13'h0005, 13'h0007, 1'b0, 1'b1, 13'h1FFE, 1'b0, 1'b0); // borrow
    beat_h(13'h0007, 13'h0005, 1'b0, 1'b1, 13'h0002, 1'b1, 1'b0); // no borrow
    beat_h(13'h0FFF, 13'h0001, 1'b0, 1'b0, 13'h1000, 1'b0, 1'b1); // +ovf
    beat_h(13'h1000, 13'h0001, 1'b0, 1'b1, 13'h0FFF, 1'b1, 1'b1); // -ovf
    beat_h(13'h0123, 13'h0456, 1'b1, 1'b0, 13'h057A, 1'b0, 1'b0); // cin add
    beat_h(13'h0010, 13'h0003, 1'b1, 1'b1, 13'h000C, 1'b1, 1'b0); // borrow-in

    // Two beats then a 3-cycle stall with junk on the inputs.
    phase = "stall";
    beat_m(13'h0ABC, 13'h1234, 1'b0, 1'b0);
    beat_m(13'h0100, 13'h1F00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 13'h1555, 13'h0AAA, 1'b1, 1'b0, mk('0, 1'b0, 1'b0));
    bubbles(LAT + 1);

    // Streaming: 20 back-to-back beats, then alternating bubbles.
    phase = "stream";
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      logic             rs;
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rc = 1'($urandom());
      rs = 1'($urandom());
      if (i < 20 || i[0] == 1'b0) beat_m(ra, rb, rc, rs);
      else bubbles(1);
    end
    bubbles(LAT + 1);

    // Mid-flight reset: one beat at the output, three in flight.
    phase = "midreset";
    beat_m(13'h0321, 13'h0123, 1'b0, 1'b0);
    beat_m(13'h0F0F, 13'h00F0, 1'b1, 1'b0);
    beat_m(13'h1111, 13'h0222, 1'b0, 1'b1);
    beat_m(13'h0444, 13'h0333, 1'b1, 1'b0);
    beat_m(13'h0777, 13'h0666, 1'b0, 1'b1);
    #1 rst = 1'b1;
    clear_model();
    #1 check_out();
    @(posedge clk);
    #1 check_out();
    rst = 1'b0;
    beat_m(13'h0ACE, 13'h0135, 1'b1, 1'b0);
    bubbles(LAT + 2);

    phase = "drain";
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_seg_pipe_adder
`default_nettype wire
